cordic_scheduler: RTL and testbench
===================================

CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, giving the number of voices sharing one sine CORDIC (range 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 64, giving the maximum Sys_clk cycles to wait for Cordic_done.
REQ-003 SHALL have parameters PI_VAL, default 32'h0003_243E, and PI2_VAL, default 32'h0006_487E, both signed 16Q.16N.
REQ-004 Sys_clk  in  1  system clock; all logic on its rising edge.
REQ-005 Sch_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 Syn_tick  in  1  one-cycle oscillator-rate strobe (1 MHz) that starts a frame.
REQ-007 Cfg_we  in  1  configuration write strobe.
REQ-008 Cfg_addr  in  3  voice index for the write; only the low clog2(NUM_VOICES) bits are used.
REQ-009 Cfg_inc  in  32  signed 16Q.16N phase increment for the voice.
REQ-010 Cfg_en  in  1  voice enable written with Cfg_inc.
REQ-011 Cfg_sync  in  1  when set with Cfg_we, zeroes the voice's phase.
REQ-012 Cordic_start  out  1  one-cycle request to the shared CORDIC.
REQ-013 Cordic_phase  out  32  signed phase presented with Cordic_start and held until Cordic_done.
REQ-014 Cordic_done  in  1  one-cycle CORDIC result-valid.
REQ-015 Cordic_wave  in  32  signed CORDIC result, valid with Cordic_done.
REQ-016 Wave_bus  out  32*NUM_VOICES  per-voice sine outputs; voice v occupies bits [32v+31:32v].
REQ-017 Frame_done  out  1  one-cycle pulse when all voices of a frame are processed.
REQ-018 Busy  out  1  high in every state except IDLE.
REQ-019 Overrun  out  1  sticky; set when Syn_tick arrives while Busy.
REQ-020 Timeout_err  out  1  sticky; set when a CORDIC request exceeds TIMEOUT cycles.

Function
REQ-021 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> STORE -> (ISSUE for the next voice | DONE) -> IDLE.
REQ-022 IDLE: Syn_tick high -> ISSUE, voice index v=0.
REQ-023 ISSUE, voice enabled: drive Cordic_start=1 for exactly one cycle with Cordic_phase=phase[v], then -> WAIT.
REQ-024 ISSUE, voice disabled: no Cordic_start; Wave_bus slot v=0; phase[v] unchanged; -> STORE on the next cycle.
REQ-025 WAIT: Cordic_done -> capture Cordic_wave into slot v and -> STORE; a Cordic_done seen outside WAIT SHALL be ignored.
REQ-026 WAIT: TIMEOUT cycles without Cordic_done -> set Timeout_err, hold slot v, -> STORE.
REQ-027 STORE, enabled voice: sum = phase[v] + inc[v] (32-bit signed, wrap-around); if sum > PI_VAL then phase[v] = sum - PI2_VAL, else phase[v] = sum.
REQ-028 STORE: if v = NUM_VOICES-1 -> DONE, else v = v+1 -> ISSUE.
REQ-029 DONE: Frame_done=1 for one cycle, then -> IDLE.
REQ-030 Cfg_we SHALL update inc[a] and en[a] on the same edge; Cfg_sync=1 also sets phase[a]=0, and this write takes priority over a STORE to the same voice on that edge.
REQ-031 An inc write during a frame SHALL take effect at the voice's next STORE; a STORE on the same edge as the write uses the old inc.
REQ-032 Disabling the voice in service while in WAIT: the result is discarded, slot v=0, phase is unchanged, and the FSM continues normally.
REQ-033 Syn_tick while Busy: set Overrun, the tick is dropped, and the frame in progress is unaffected.
REQ-034 Overrun and Timeout_err SHALL clear only on reset.

Reset
REQ-035 While Sch_rst_n=0: state=IDLE, v=0, and all phase, inc, en, Wave_bus, Cordic_start, Cordic_phase, Frame_done, Busy, Overrun and Timeout_err = 0.
REQ-036 Reset mid-frame SHALL abandon the request immediately; a late Cordic_done after release SHALL be ignored, because the FSM is in IDLE.

Verification
REQ-037 Voice 0: inc=32'h0000_1000, enabled, CORDIC model answers in 3 cycles; 3 ticks -> Cordic_phase values 0, 0x1000, 0x2000, and phase[0]=0x3000 after frame 3.
REQ-038 Wrap: phase=0x0003_2000, inc=0x0000_3000 -> after STORE, phase=0xFFFD_0782.
REQ-039 Voices 1..3 disabled -> exactly one Cordic_start per frame, slots 1..3 read 0, and Frame_done fires.
REQ-040 Syn_tick pulsed twice, 2 cycles apart -> Overrun=1, and only one Frame_done.
REQ-041 CORDIC model never asserts done -> Timeout_err=1 after 64 WAIT cycles, and the frame still completes.
REQ-042 Sch_rst_n low during WAIT, with a late Cordic_done after release -> all outputs 0, Busy=0, and no Frame_done.

Source files
------------

// File: rtl/cordic_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cordic_scheduler
// Description : Time-multiplexes one shared sine CORDIC across NUM_VOICES
//               phase accumulators, one pass over all voices per Syn_tick.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_scheduler #(
    parameter int                 NUM_VOICES = 4,
    parameter int                 TIMEOUT    = 64,
    parameter logic signed [31:0] PI_VAL     = 32'sh0003_243E,
    parameter logic signed [31:0] PI2_VAL    = 32'sh0006_487E
) (
    input  logic                      Sys_clk,
    input  logic                      Sch_rst_n,
    input  logic                      Syn_tick,
    input  logic                      Cfg_we,
    input  logic [2:0]                Cfg_addr,
    input  logic [31:0]               Cfg_inc,
    input  logic                      Cfg_en,
    input  logic                      Cfg_sync,
    output logic                      Cordic_start,
    output logic [31:0]               Cordic_phase,
    input  logic                      Cordic_done,
    input  logic [31:0]               Cordic_wave,
    output logic [32*NUM_VOICES-1:0]  Wave_bus,
    output logic                      Frame_done,
    output logic                      Busy,
    output logic                      Overrun,
    output logic                      Timeout_err
);

    localparam int              AW     = $clog2(NUM_VOICES);
    localparam int              TW     = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0]   LAST_V = AW'(NUM_VOICES - 1);
    localparam logic [AW:0]     NV     = (AW + 1)'(NUM_VOICES);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          v_q, v_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [31:0]            phase_q [NUM_VOICES];
    logic [31:0]            inc_q   [NUM_VOICES];
    logic [31:0]            wave_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0]  en_q;
    logic [31:0]            cphase_q;
    logic                   overrun_q;
    logic                   timeout_q;

    logic                   w_timeout;
    logic [AW-1:0]          w_addr;
    logic                   w_addr_ok;
    logic [31:0]            w_sum;
    logic [31:0]            w_next_phase;

    // Non-power-of-two voice counts leave holes in the address space; ignore them.
    assign w_addr    = Cfg_addr[AW-1:0];
    assign w_addr_ok = ({1'b0, w_addr} < NV);

    generate
        if (AW < 3) begin : g_addr_unused
            logic w_addr_unused;
            assign w_addr_unused = ^Cfg_addr[2:AW];
        end
    endgenerate

    assign w_sum        = phase_q[v_q] + inc_q[v_q];
    assign w_next_phase = ($signed(w_sum) > PI_VAL) ? (w_sum - PI2_VAL) : w_sum;

    always_ff @(posedge Sys_clk or negedge Sch_rst_n) begin
        if (!Sch_rst_n) begin
            state_q <= S_IDLE;
            v_q     <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        timer_d   = timer_q;
        w_timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Syn_tick) begin
                    state_d = S_ISSUE;
                    v_d     = '0;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = en_q[v_q] ? S_WAIT : S_STORE;
            end
            S_WAIT: begin
                if (Cordic_done) begin
                    state_d = S_STORE;
                end else if (timer_q == T_LAST) begin
                    w_timeout = 1'b1;
                    state_d   = S_STORE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_STORE: begin
                if (v_q == LAST_V) begin
                    state_d = S_DONE;
                end else begin
                    v_d     = v_q + AW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                v_d     = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Busy         = (state_q != S_IDLE);
    assign Frame_done   = (state_q == S_DONE);
    assign Cordic_start = (state_q == S_ISSUE) && en_q[v_q];
    assign Cordic_phase = Cordic_start ? phase_q[v_q] : cphase_q;
    assign Overrun      = overrun_q;
    assign Timeout_err  = timeout_q;

    always_ff @(posedge Sys_clk or negedge Sch_rst_n) begin
        if (!Sch_rst_n) begin
            en_q      <= '0;
            cphase_q  <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
                inc_q[i]   <= '0;
                wave_q[i]  <= '0;
            end
        end else begin
            if (Syn_tick && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            if (w_timeout) begin
                timeout_q <= 1'b1;
            end
            if (Cordic_start) begin
                cphase_q <= phase_q[v_q];
            end
            if ((state_q == S_ISSUE) && !en_q[v_q]) begin
                wave_q[v_q] <= '0;
            end
            // A voice disabled while its request is outstanding drops the result.
            if ((state_q == S_WAIT) && (state_d == S_STORE)) begin
                if (!en_q[v_q]) begin
                    wave_q[v_q] <= '0;
                end else if (Cordic_done) begin
                    wave_q[v_q] <= Cordic_wave;
                end
            end
            if ((state_q == S_STORE) && en_q[v_q]) begin
                phase_q[v_q] <= w_next_phase;
            end
            // Placed last so a sync write overrides a same-edge accumulator update.
            if (Cfg_we && w_addr_ok) begin
                inc_q[w_addr] <= Cfg_inc;
                en_q[w_addr]  <= Cfg_en;
                if (Cfg_sync) begin
                    phase_q[w_addr] <= '0;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_VOICES; g++) begin : g_wave
            assign Wave_bus[32*g +: 32] = wave_q[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cordic_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_scheduler
// Description : Self-checking bench for cordic_scheduler with a CORDIC responder
//               model and a phase scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_scheduler;

    localparam int          NV    = 4;
    localparam logic [31:0] PI_V  = 32'h0003_243E;
    localparam logic [31:0] PI2_V = 32'h0006_487E;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              syn_tick  = 1'b0;
    logic              cfg_we    = 1'b0;
    logic [2:0]        cfg_addr  = 3'd0;
    logic [31:0]       cfg_inc   = 32'd0;
    logic              cfg_en    = 1'b0;
    logic              cfg_sync  = 1'b0;
    logic              cordic_start;
    logic [31:0]       cordic_phase;
    logic              cordic_done = 1'b0;
    logic [31:0]       cordic_wave = 32'd0;
    logic [32*NV-1:0]  wave_bus;
    logic              frame_done, busy, overrun, timeout_err;

    always #5 clk = ~clk;

    cordic_scheduler #(.NUM_VOICES(NV), .TIMEOUT(64)) dut (
        .Sys_clk      (clk),
        .Sch_rst_n    (rst_n),
        .Syn_tick     (syn_tick),
        .Cfg_we       (cfg_we),
        .Cfg_addr     (cfg_addr),
        .Cfg_inc      (cfg_inc),
        .Cfg_en       (cfg_en),
        .Cfg_sync     (cfg_sync),
        .Cordic_start (cordic_start),
        .Cordic_phase (cordic_phase),
        .Cordic_done  (cordic_done),
        .Cordic_wave  (cordic_wave),
        .Wave_bus     (wave_bus),
        .Frame_done   (frame_done),
        .Busy         (busy),
        .Overrun      (overrun),
        .Timeout_err  (timeout_err)
    );

    // Responder state (written only by the responder process)
    int          resp_cnt    = 0;
    logic [31:0] resp_wave   = 32'd0;
    int          inject_seen = 0;
    logic [31:0] obs_q[$];
    int          n_starts    = 0;
    logic [31:0] last_phase  = 32'd0;

    // Responder controls (written only by the main process)
    int          resp_lat    = 3;
    bit          mute        = 1'b0;
    int          inject_cnt  = 0;
    logic [31:0] inject_wave = 32'd0;

    logic [31:0] m_phase  [NV];
    logic [31:0] m_inc    [NV];
    logic        m_en     [NV];
    logic [31:0] exp_wave [NV];
    logic [31:0] exp_q[$];
    int          exp_rd = 0;
    int          obs_rd = 0;
    int          n_checks = 0;
    int          n_err    = 0;

    typedef struct {
        logic [31:0] inc_a;
        logic [31:0] inc_b;
        logic [31:0] exp_p1;
        logic [31:0] exp_p2;
    } vec_t;
    vec_t vecs [6];

    function automatic logic [31:0] wave_of(input logic [31:0] p);
        return {p[15:0], p[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] step(input logic [31:0] p, input logic [31:0] inc);
        logic [31:0] s;
        s = p + inc;
        if ($signed(s) > $signed(PI_V)) s = s - PI2_V;
        return s;
    endfunction

    always @(negedge clk) begin
        cordic_done = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                cordic_done = 1'b1;
                cordic_wave = resp_wave;
            end
        end
        if (inject_cnt != inject_seen) begin
            inject_seen = inject_cnt;
            cordic_done = 1'b1;
            cordic_wave = inject_wave;
        end
        if (cordic_start === 1'b1) begin
            obs_q.push_back(cordic_phase);
            last_phase = cordic_phase;
            n_starts++;
            if (!mute) begin
                resp_cnt  = resp_lat;
                resp_wave = wave_of(cordic_phase);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_slots(input string tag);
        for (int v = 0; v < NV; v++)
            check($sformatf("%s_slot%0d", tag, v), wave_bus[32*v +: 32], exp_wave[v]);
    endtask

    task automatic model_clear();
        for (int v = 0; v < NV; v++) begin
            m_phase[v]  = 32'd0;
            m_inc[v]    = 32'd0;
            m_en[v]     = 1'b0;
            exp_wave[v] = 32'd0;
        end
    endtask

    task automatic cfg_write(input int a, input logic [31:0] inc, input logic en, input logic sync);
        cfg_addr = 3'(a);
        cfg_inc  = inc;
        cfg_en   = en;
        cfg_sync = sync;
        cfg_we   = 1'b1;
        @(negedge clk);
        cfg_we   = 1'b0;
        cfg_sync = 1'b0;
        m_inc[a] = inc;
        m_en[a]  = en;
        if (sync) m_phase[a] = 32'd0;
    endtask

    task automatic pulse_tick();
        syn_tick = 1'b1;
        @(negedge clk);
        syn_tick = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int cnt;
        cnt = 0;
        while (frame_done !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_frame_done"}, 32'(frame_done), 32'd1);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        while (obs_rd < obs_q.size()) begin
            if (exp_rd < exp_q.size()) begin
                check($sformatf("%s_sb_phase", tag), obs_q[obs_rd], exp_q[exp_rd]);
                exp_rd++;
            end else begin
                n_checks++;
                n_err++;
                $display("FAIL %s_sb: unexpected Cordic_start with phase %h, required none", tag, obs_q[obs_rd]);
            end
            obs_rd++;
        end
        if (exp_rd < exp_q.size()) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_sb: got %0d starts too few, required 0 missing", tag, exp_q.size() - exp_rd);
            exp_rd = exp_q.size();
        end
    endtask

    task automatic run_frame(input string tag);
        int ns0;
        int nexp;
        ns0  = n_starts;
        nexp = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_en[v]) begin
                exp_q.push_back(m_phase[v]);
                nexp++;
                if (!mute) exp_wave[v] = wave_of(m_phase[v]);
                m_phase[v] = step(m_phase[v], m_inc[v]);
            end else begin
                exp_wave[v] = 32'd0;
            end
        end
        pulse_tick();
        wait_frame(tag);
        check({tag, "_starts"}, 32'(n_starts - ns0), 32'(nexp));
        check_slots(tag);
        drain(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int nfd;
        int nbusy;

        vecs[0] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_2000};
        vecs[1] = '{32'h0003_2000, 32'h0000_3000, 32'h0003_2000, 32'hFFFD_0782};
        vecs[2] = '{32'h0003_243E, 32'h0000_0001, 32'h0003_243E, 32'hFFFC_DBC1};
        vecs[3] = '{32'h0003_243F, 32'h0000_0000, 32'hFFFC_DBC1, 32'hFFFC_DBC1};
        vecs[4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFE_0000};
        vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FF9_B781, 32'hFFF9_B780};
        model_clear();

        repeat (3) @(negedge clk);
        check("rst_start",   32'(cordic_start), 32'd0);
        check("rst_phase",   cordic_phase,      32'd0);
        check("rst_fdone",   32'(frame_done),   32'd0);
        check("rst_busy",    32'(busy),         32'd0);
        check("rst_overrun", 32'(overrun),      32'd0);
        check("rst_timeout", 32'(timeout_err),  32'd0);
        check_slots("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Single-voice accumulation and wrap boundaries
        for (int i = 0; i < 6; i++) begin
            cfg_write(0, vecs[i].inc_a, 1'b1, 1'b1);
            run_frame($sformatf("row%0d_f1", i));
            check($sformatf("row%0d_p0", i), last_phase, 32'd0);
            cfg_write(0, vecs[i].inc_b, 1'b1, 1'b0);
            run_frame($sformatf("row%0d_f2", i));
            check($sformatf("row%0d_p1", i), last_phase, vecs[i].exp_p1);
            run_frame($sformatf("row%0d_f3", i));
            check($sformatf("row%0d_p2", i), last_phase, vecs[i].exp_p2);
        end

        // All voices active
        cfg_write(0, 32'h0001_1111, 1'b1, 1'b1);
        cfg_write(1, 32'h0002_0000, 1'b1, 1'b1);
        cfg_write(2, 32'hFFFF_8000, 1'b1, 1'b1);
        cfg_write(3, 32'h0003_0000, 1'b1, 1'b1);
        run_frame("multi_f1");
        run_frame("multi_f2");
        run_frame("multi_f3");
        for (int v = 1; v < NV; v++) cfg_write(v, m_inc[v], 1'b0, 1'b0);
        run_frame("solo");

        // Stray done while idle
        inject_wave = 32'hDEAD_BEEF;
        inject_cnt++;
        repeat (3) @(negedge clk);
        check_slots("stray_done");
        check("stray_busy", 32'(busy), 32'd0);

        // Voice disabled while its request is outstanding
        resp_lat = 8;
        exp_q.push_back(m_phase[0]);
        pulse_tick();
        @(negedge clk);
        cfg_write(0, m_inc[0], 1'b0, 1'b0);
        exp_wave[0] = 32'd0;
        wait_frame("dis");
        check_slots("dis");
        drain("dis");
        resp_lat = 3;
        cfg_write(0, m_inc[0], 1'b1, 1'b0);
        run_frame("reen");

        // Sync write on the STORE edge wins
        exp_q.push_back(m_phase[0]);
        exp_wave[0] = wave_of(m_phase[0]);
        pulse_tick();
        cnt = 0;
        while (cordic_done !== 1'b1 && cnt < 40) begin
            @(posedge clk);
            cnt++;
        end
        @(negedge clk);
        cfg_write(0, m_inc[0], 1'b1, 1'b1);
        wait_frame("sync");
        check_slots("sync");
        drain("sync");
        run_frame("post_sync");

        // CORDIC never answers
        mute = 1'b1;
        exp_q.push_back(m_phase[0]);
        syn_tick = 1'b1;
        cnt = 0;
        while (cnt < 200) begin
            @(negedge clk);
            syn_tick = 1'b0;
            cnt++;
            if (timeout_err === 1'b1) break;
        end
        check("tmo_latency", 32'(cnt), 32'd66);
        wait_frame("tmo");
        m_phase[0] = step(m_phase[0], m_inc[0]);
        check_slots("tmo");
        drain("tmo");
        mute = 1'b0;
        run_frame("post_tmo");
        check("tmo_sticky", 32'(timeout_err), 32'd1);

        // Overrun: second tick two cycles after the first
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        check("ovr_tmo_cleared", 32'(timeout_err), 32'd0);
        cfg_write(0, 32'h0000_1000, 1'b1, 1'b1);
        exp_q.push_back(m_phase[0]);
        exp_wave[0] = wave_of(m_phase[0]);
        m_phase[0] = step(m_phase[0], m_inc[0]);
        syn_tick = 1'b1;
        @(negedge clk);
        syn_tick = 1'b0;
        @(negedge clk);
        syn_tick = 1'b1;
        @(negedge clk);
        syn_tick = 1'b0;
        nfd = 0;
        repeat (60) begin
            @(negedge clk);
            if (frame_done === 1'b1) nfd++;
        end
        check("ovr_frames",  32'(nfd),     32'd1);
        check("ovr_flag",    32'(overrun), 32'd1);
        check("ovr_busy",    32'(busy),    32'd0);
        check_slots("ovr");
        drain("ovr");

        // Reset during WAIT, late done after release
        resp_lat = 10;
        exp_q.push_back(m_phase[0]);
        pulse_tick();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        check("mrst_start",   32'(cordic_start), 32'd0);
        check("mrst_phase",   cordic_phase,      32'd0);
        check("mrst_fdone",   32'(frame_done),   32'd0);
        check("mrst_busy",    32'(busy),         32'd0);
        check("mrst_overrun", 32'(overrun),      32'd0);
        check("mrst_timeout", 32'(timeout_err),  32'd0);
        check_slots("mrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nfd   = 0;
        nbusy = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_done === 1'b1) nfd++;
            if (busy === 1'b1) nbusy++;
        end
        check("mrst_frames", 32'(nfd),   32'd0);
        check("mrst_nbusy",  32'(nbusy), 32'd0);
        check("mrst_phase2", cordic_phase, 32'd0);
        check_slots("mrst_late");
        drain("mrst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
